// File: rtl/pipe_stall_flush_ctrl.sv
// Pipeline hazard controller. It resolves per-stage stall and redirect requests into
// stall, bubble and flush vectors, and holds a flush for several cycles after a redirect.
// It also keeps a saturating stall-cycle counter and a sticky stall watchdog.
module pipe_stall_flush_ctrl #(
  parameter int unsigned STAGES       = 6,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned WDOG_LIMIT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic [STAGES-1:0] flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              hang
);

  localparam int unsigned IdxW  = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int unsigned WdogW = 10;
  localparam logic [WdogW-1:0] WdogLim  = WdogW'(WDOG_LIMIT);
  localparam logic [3:0]       HoldLoad = 4'(FLUSH_CYCLES - 1);

  // Highest requesting stage for stall (s) and flush (f)
  logic [IdxW-1:0] s_idx, f_idx;
  logic            s_any, f_any;

  // Raw resolution before the flush override
  logic [STAGES-1:0] stall_raw, bubble_raw, fmask_new, flush_eff;

  // Flush hold state
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic [STAGES-1:0] hold_mask_q, hold_mask_d;
  logic [IdxW-1:0]   hold_f_q, hold_f_d;
  logic              hold_act, new_req;

  // Counters and watchdog state
  logic [CNT_W-1:0] stall_cnt_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic [IdxW-1:0]  wdog_s_q, wdog_s_d;
  logic             wdog_vld_q, wdog_vld_d;
  logic             hang_d;
  logic             any_stall;

  // Priority encoders: ascending scan so the highest (oldest) request wins
  always_comb begin
    s_idx = '0;
    s_any = 1'b0;
    f_idx = '0;
    f_any = 1'b0;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (stall_req[i]) begin
        s_idx = IdxW'(i);
        s_any = 1'b1;
      end
      if (flush_req[i]) begin
        f_idx = IdxW'(i);
        f_any = 1'b1;
      end
    end
  end

  // Raw stall/bubble/flush masks derived from s and f
  always_comb begin
    stall_raw  = '0;
    bubble_raw = '0;
    fmask_new  = '0;
    for (int j = 0; j < int'(STAGES); j++) begin
      stall_raw[j]  = s_any && (j <= int'(s_idx));
      bubble_raw[j] = s_any && (j == int'(s_idx) + 1);
      fmask_new[j]  = f_any && (j < int'(f_idx));
    end
  end

  assign hold_act  = (hold_cnt_q != 4'd0);
  // A redirect from stage 0 has no younger stage to discard, so it is ignored
  assign new_req   = f_any && (f_idx != '0);
  assign flush_eff = fmask_new | (hold_act ? hold_mask_q : '0);

  // Output resolution: freeze on reset or !rdy, otherwise flush overrides stall/bubble
  always_comb begin
    if (rst || !rdy) begin
      stall  = '1;
      bubble = '0;
      flush  = '0;
    end else begin
      flush  = flush_eff;
      stall  = stall_raw & ~flush_eff;
      bubble = bubble_raw & ~flush_eff;
    end
  end

  assign any_stall = |stall;

  // Flush hold next state: reload on a new redirect, otherwise count down
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    hold_mask_d = hold_mask_q;
    hold_f_d    = hold_f_q;
    if (rdy) begin
      if (new_req) begin
        hold_cnt_d = HoldLoad;
        if (!hold_act || (f_idx >= hold_f_q)) begin
          hold_mask_d = fmask_new;
          hold_f_d    = f_idx;
        end else begin
          hold_mask_d = hold_mask_q | fmask_new;
        end
      end else if (hold_act) begin
        hold_cnt_d = hold_cnt_q - 4'd1;
      end
    end
  end

  // Stall counter and watchdog next state; the first cycle of a new s counts as one
  always_comb begin
    stall_cnt_d = stall_cnt;
    wdog_d      = wdog_q;
    wdog_s_d    = wdog_s_q;
    wdog_vld_d  = wdog_vld_q;
    if (rdy) begin
      if (any_stall && (stall_cnt != '1)) begin
        stall_cnt_d = stall_cnt + 1'b1;
      end
      if (!any_stall) begin
        wdog_d     = '0;
        wdog_vld_d = 1'b0;
      end else begin
        if (wdog_vld_q && (s_idx == wdog_s_q)) begin
          wdog_d = (wdog_q >= WdogLim) ? wdog_q : wdog_q + 1'b1;
        end else begin
          wdog_d = WdogW'(1);
        end
        wdog_s_d   = s_idx;
        wdog_vld_d = 1'b1;
      end
    end
    hang_d = hang | (wdog_d >= WdogLim);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q  <= 4'd0;
      hold_mask_q <= '0;
      hold_f_q    <= '0;
      stall_cnt   <= '0;
      wdog_q      <= '0;
      wdog_s_q    <= '0;
      wdog_vld_q  <= 1'b0;
      hang        <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      hold_mask_q <= hold_mask_d;
      hold_f_q    <= hold_f_d;
      stall_cnt   <= stall_cnt_d;
      wdog_q      <= wdog_d;
      wdog_s_q    <= wdog_s_d;
      wdog_vld_q  <= wdog_vld_d;
      hang        <= hang_d;
    end
  end

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Bench for pipe_stall_flush_ctrl: vector table with scoreboard queue plus corner sequences.
module tb_pipe_stall_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [5:0] stall_req, flush_req;
  logic [5:0] stall, bubble, flush;
  logic [5:0] s_stall, s_bubble, s_flush;
  logic [15:0] stall_cnt;
  logic [3:0]  s_stall_cnt;
  logic        hang, s_hang;

  always #5 clk = ~clk;

  pipe_stall_flush_ctrl #(
    .STAGES(6), .FLUSH_CYCLES(3), .CNT_W(16), .WDOG_LIMIT(1023)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req), .flush_req(flush_req),
    .stall(stall), .bubble(bubble), .flush(flush), .stall_cnt(stall_cnt), .hang(hang)
  );

  pipe_stall_flush_ctrl #(
    .STAGES(6), .FLUSH_CYCLES(3), .CNT_W(4), .WDOG_LIMIT(1023)
  ) dut_sat (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req), .flush_req(flush_req),
    .stall(s_stall), .bubble(s_bubble), .flush(s_flush), .stall_cnt(s_stall_cnt),
    .hang(s_hang)
  );

  typedef struct {
    logic       rdy;
    logic [5:0] sr;
    logic [5:0] fr;
    logic [5:0] st;
    logic [5:0] bu;
    logic [5:0] fl;
  } vec_t;

  vec_t tbl[25];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  function automatic vec_t mk(input logic r, input logic [5:0] sr, input logic [5:0] fr,
                              input logic [5:0] st, input logic [5:0] bu,
                              input logic [5:0] fl);
    vec_t v;
    v.rdy = r; v.sr = sr; v.fr = fr; v.st = st; v.bu = bu; v.fl = fl;
    return v;
  endfunction

  task automatic check_v(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    rdy       = v.rdy;
    stall_req = v.sr;
    flush_req = v.fr;
    exp_q.push_back(v);
    if (v.rdy && (v.st != 6'b0)) exp_cnt++;
    @(negedge clk);
    e = exp_q.pop_front();
    check_v($sformatf("row%0d stall", idx), stall, e.st);
    check_v($sformatf("row%0d bubble", idx), bubble, e.bu);
    check_v($sformatf("row%0d flush", idx), flush, e.fl);
    check_v($sformatf("row%0d sat_stall", idx), s_stall, e.st);
    check_v($sformatf("row%0d sat_flush", idx), s_flush, e.fl);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    stall_req = '0;
    flush_req = '0;
    rdy       = 1'b1;
    rst       = 1'b1;
    #2;
    rst       = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         rdy   stall_req  flush_req  stall      bubble     flush
    tbl[0]  = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000);
    tbl[1]  = mk(1, 6'b001000, 6'b000000, 6'b001111, 6'b010000, 6'b000000);
    tbl[2]  = mk(1, 6'b001010, 6'b000000, 6'b001111, 6'b010000, 6'b000000);
    tbl[3]  = mk(1, 6'b100000, 6'b000000, 6'b111111, 6'b000000, 6'b000000);
    tbl[4]  = mk(1, 6'b000001, 6'b000000, 6'b000001, 6'b000010, 6'b000000);
    tbl[5]  = mk(1, 6'b000000, 6'b010000, 6'b000000, 6'b000000, 6'b001111);
    tbl[6]  = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001111);
    tbl[7]  = mk(0, 6'b000000, 6'b000000, 6'b111111, 6'b000000, 6'b000000);
    tbl[8]  = mk(0, 6'b000000, 6'b000000, 6'b111111, 6'b000000, 6'b000000);
    tbl[9]  = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001111);
    tbl[10] = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000);
    tbl[11] = mk(1, 6'b010000, 6'b001000, 6'b011000, 6'b100000, 6'b000111);
    tbl[12] = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000111);
    tbl[13] = mk(1, 6'b000100, 6'b010000, 6'b000000, 6'b000000, 6'b001111);
    tbl[14] = mk(1, 6'b000000, 6'b000100, 6'b000000, 6'b000000, 6'b001111);
    tbl[15] = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001111);
    tbl[16] = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001111);
    tbl[17] = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000);
    tbl[18] = mk(1, 6'b000000, 6'b000001, 6'b000000, 6'b000000, 6'b000000);
    tbl[19] = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000);
    tbl[20] = mk(1, 6'b100000, 6'b100000, 6'b100000, 6'b000000, 6'b011111);
    tbl[21] = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b011111);
    tbl[22] = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b011111);
    tbl[23] = mk(1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000);
    tbl[24] = mk(0, 6'b100000, 6'b000000, 6'b111111, 6'b000000, 6'b000000);

    rst = 1'b1; rdy = 1'b1; stall_req = '0; flush_req = '0;
    #12;
    check_v("reset stall", stall, 6'b111111);
    check_v("reset bubble", bubble, 6'b000000);
    check_v("reset flush", flush, 6'b000000);
    check_n("reset stall_cnt", int'(stall_cnt), 0);
    check_n("reset hang", int'(hang), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Async reset in the middle of a flush hold
    stall_req = 6'b001000;
    @(posedge clk); #1;
    stall_req = '0;
    flush_req = 6'b010000;
    @(posedge clk); #1;
    flush_req = '0;
    check_v("hold before rst", flush, 6'b001111);
    check_n("cnt before rst", int'(stall_cnt), 1);
    #3;
    rst = 1'b1;
    #1;
    check_v("async rst flush", flush, 6'b000000);
    check_v("async rst stall", stall, 6'b111111);
    check_n("async rst stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_v("post rst stall", stall, 6'b000000);
    check_v("post rst flush", flush, 6'b000000);

    exp_cnt = 0;
    for (int i = 0; i < 25; i++) step(tbl[i], i);
    check_n("table stall_cnt", int'(stall_cnt), exp_cnt);
    check_n("table sat stall_cnt", int'(s_stall_cnt), (exp_cnt > 15) ? 15 : exp_cnt);

    // Counter saturation
    rst_pulse();
    stall_req = 6'b000100;
    repeat (20) @(posedge clk);
    #1;
    check_n("wide stall_cnt 20", int'(stall_cnt), 20);
    check_n("narrow stall_cnt sat", int'(s_stall_cnt), 15);

    // Watchdog restarts when s changes
    rst_pulse();
    stall_req = 6'b100000;
    repeat (600) @(posedge clk);
    stall_req = 6'b010000;
    repeat (600) @(posedge clk);
    #1;
    check_n("wdog s change hang", int'(hang), 0);

    // Watchdog trip on the 1023rd counted cycle
    rst_pulse();
    stall_req = 6'b100000;
    repeat (1022) @(posedge clk);
    #1;
    check_n("hang at 1022", int'(hang), 0);
    @(posedge clk); #1;
    check_n("hang at 1023", int'(hang), 1);
    check_n("stall_cnt at 1023", int'(stall_cnt), 1023);
    stall_req = '0;
    repeat (3) @(posedge clk);
    #1;
    check_n("hang sticky", int'(hang), 1);
    check_n("sat hang sticky", int'(s_hang), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
